// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered reset sequencer for the ESN datapath.
// A global asynchronous reset (rst_N) or a synchronised falling edge on the
// soft request (req_N) holds all N_CH downstream reset lines low for
// PULSE_LEN cycles. The lines are then released one after another, DLY
// cycles apart, with channel 0 first. busy is high while a sequence runs.
// done is a one-cycle strobe on the edge that releases the last channel.
// Optional feature macro: RST_SEQ_RETRIG_EN. When it is defined, a new
// request while busy restarts the sequence. When it is undefined, such a
// request is discarded.
module rst_seq_gen #(
  parameter int N_CH      = 2,
  parameter int PULSE_LEN = 6,
  parameter int DLY       = 4,
  parameter int CW        = 8
) (
  input  logic            clk,
  input  logic            rst_N,
  input  logic            req_N,
  output logic [N_CH-1:0] rst_out_N,
  output logic            busy,
  output logic            done
);

  // Count value at which the last channel releases.
  localparam int LAST_AT = PULSE_LEN - 1 + (N_CH - 1) * DLY;
  localparam logic [N_CH-1:0] ALL_ONES = {N_CH{1'b1}};

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [N_CH-1:0] rst_out_next;
  logic            busy_next;
  logic            done_next;

  logic [1:0]      sync;
  logic            edge_det;
  logic            trig;
  logic [N_CH-1:0] rel_hit;

  // Refuse parameter sets that the counter cannot sequence.
  generate
    if (N_CH < 1 || PULSE_LEN < 1 || DLY < 0 || CW < 1 ||
        longint'(LAST_AT) >= (longint'(1) << CW)) begin : g_bad_params
      $error("rst_seq_gen: invalid parameters (N_CH>=1, PULSE_LEN>=1, DLY>=0, last release count must fit in CW bits)");
    end
  endgenerate

  // Falling edge of the synchronised request: the older sample is high and
  // the newer sample is low.
  assign edge_det = sync[1] & ~sync[0];

  // Two-flop synchroniser for req_N, followed by a registered edge strobe.
  // The strobe flop gives the documented latency: a low req_N captured at
  // edge k pulls the outputs low at edge k+2.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      sync <= 2'b11;
      trig <= 1'b0;
    end else begin
      sync <= {sync[0], req_N};
      trig <= edge_det;
    end
  end

  // Per-channel release match. Channel gi is released on the edge where
  // count equals PULSE_LEN-1+gi*DLY. When DLY is 0, every channel matches
  // the same count, so all channels release together.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rel
      localparam int REL_AT = PULSE_LEN - 1 + gi * DLY;
      assign rel_hit[gi] = (count == CW'(REL_AT));
    end
  endgenerate

  // State and output registers. The power-on reset starts a full sequence
  // from count 0, exactly as a soft request does.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state     <= ASSERT;
      count     <= '0;
      rst_out_N <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      rst_out_N <= rst_out_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Next-state logic for the sequencer and for every registered output.
  always_comb begin
    state_next   = state;
    count_next   = count;
    rst_out_next = rst_out_N;
    busy_next    = busy;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        count_next   = '0;
        rst_out_next = ALL_ONES;
        busy_next    = 1'b0;
        if (trig) begin
          state_next   = ASSERT;
          rst_out_next = '0;
          busy_next    = 1'b1;
        end
      end

      ASSERT: begin
        count_next = count + CW'(1);
        // Channels released earlier stay high. New matches add to them.
        rst_out_next = rst_out_N | rel_hit;
        if (rel_hit[N_CH-1]) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          count_next = '0;
        end
`ifdef RST_SEQ_RETRIG_EN
        // A new request overrides everything else, including the final
        // release: the running sequence is abandoned without a done strobe.
        if (trig) begin
          state_next   = ASSERT;
          count_next   = '0;
          rst_out_next = '0;
          busy_next    = 1'b1;
          done_next    = 1'b0;
        end
`else
        // A request while busy is dropped. The strobe lasts one cycle, so
        // nothing is left pending when the sequence completes.
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed testbench for rst_seq_gen.
// The default instance uses N_CH=2, PULSE_LEN=6, DLY=4. The small instance
// uses N_CH=4, PULSE_LEN=1, DLY=0. Timing is counted in edges after the
// edge k that first samples req_N low, and expected values are written
// out from that edge numbering.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_N, req_N;
  logic [1:0] rst_out_N;
  logic       busy, done;

  logic       rst2_N, req2_N;
  logic [3:0] rst_out2_N;
  logic       busy2, done2;

  int pass_cnt  = 0;
  int check_cnt = 0;

  rst_seq_gen #(.N_CH(2), .PULSE_LEN(6), .DLY(4), .CW(8)) dut (
    .clk      (clk),
    .rst_N    (rst_N),
    .req_N    (req_N),
    .rst_out_N(rst_out_N),
    .busy     (busy),
    .done     (done)
  );

  rst_seq_gen #(.N_CH(4), .PULSE_LEN(1), .DLY(0), .CW(8)) dut_small (
    .clk      (clk),
    .rst_N    (rst2_N),
    .req_N    (req2_N),
    .rst_out_N(rst_out2_N),
    .busy     (busy2),
    .done     (done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Power-on reset of both instances, then the full default sequence.
  task automatic test_reset();
    logic [3:0] got, exp;
    logic [5:0] got2, exp2;
    for (int c = 0; c < 3; c++) begin
      tick();
      got = {rst_out_N, busy, done};
      exp = 4'b0010;
      check_cnt++;
      if (got !== exp) $display("FAIL reset_hold c=%0d out/busy/done=%b expected %b", c, got, exp);
      else pass_cnt++;
      got2 = {rst_out2_N, busy2, done2};
      exp2 = 6'b000010;
      check_cnt++;
      if (got2 !== exp2) $display("FAIL reset_hold_small c=%0d out/busy/done=%b expected %b", c, got2, exp2);
      else pass_cnt++;
    end
    rst_N  = 1'b1;
    rst2_N = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      got = {rst_out_N, busy, done};
      exp = {(n >= 10), (n >= 6), (n < 10), (n == 10)};
      check_cnt++;
      if (got !== exp) $display("FAIL power_on n=%0d out/busy/done=%b expected %b", n, got, exp);
      else pass_cnt++;
      if (n <= 2) begin
        got2 = {rst_out2_N, busy2, done2};
        exp2 = {4'b1111, 1'b0, (n == 1)};
        check_cnt++;
        if (got2 !== exp2) $display("FAIL power_on_small n=%0d out/busy/done=%b expected %b", n, got2, exp2);
        else pass_cnt++;
      end
    end
    $display("test_reset: power-on sequences checked");
  endtask

  // Soft request from IDLE, then req_N held low with no second sequence.
  task automatic test_soft();
    logic [3:0] got, exp;
    repeat (3) tick();
    req_N = 1'b0;
    for (int j = 0; j <= 14; j++) begin
      tick();
      got = {rst_out_N, busy, done};
      exp = {!(j >= 2 && j < 12), !(j >= 2 && j < 8), (j >= 2 && j < 12), (j == 12)};
      check_cnt++;
      if (got !== exp) $display("FAIL soft j=%0d out/busy/done=%b expected %b", j, got, exp);
      else pass_cnt++;
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      got = {rst_out_N, busy, done};
      exp = 4'b1100;
      check_cnt++;
      if (got !== exp) $display("FAIL soft_hold c=%0d out/busy/done=%b expected %b", c, got, exp);
      else pass_cnt++;
    end
    req_N = 1'b1;
    repeat (3) tick();
    $display("test_soft: soft request and held-low request checked");
  endtask

  // Small instance: one-cycle pulse with every channel released together.
  task automatic test_short();
    logic [5:0] got, exp;
    req2_N = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      tick();
      got = {rst_out2_N, busy2, done2};
      if (j == 2) exp = 6'b000010;
      else        exp = {4'b1111, 1'b0, (j == 3)};
      check_cnt++;
      if (got !== exp) $display("FAIL short j=%0d out/busy/done=%b expected %b", j, got, exp);
      else pass_cnt++;
      if (j == 2) req2_N = 1'b1;
    end
    $display("test_short: N_CH=4 PULSE_LEN=1 DLY=0 checked");
  endtask

  // rst_N pulsed low for one cycle while count = 3 in a soft sequence.
  task automatic test_abort();
    logic [3:0] got, exp;
    repeat (3) tick();
    req_N = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      tick();
      got = {rst_out_N, busy, done};
      exp = {!(j >= 2), !(j >= 2), (j >= 2), 1'b0};
      check_cnt++;
      if (got !== exp) $display("FAIL abort_pre j=%0d out/busy/done=%b expected %b", j, got, exp);
      else pass_cnt++;
      if (j == 2) req_N = 1'b1;
    end
    rst_N = 1'b0;
    #1;
    got = {rst_out_N, busy, done};
    check_cnt++;
    if (got !== 4'b0010) $display("FAIL abort_async out/busy/done=%b expected 0010", got);
    else pass_cnt++;
    tick();
    rst_N = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      got = {rst_out_N, busy, done};
      exp = {(n >= 10), (n >= 6), (n < 10), (n == 10)};
      check_cnt++;
      if (got !== exp) $display("FAIL abort_restart n=%0d out/busy/done=%b expected %b", n, got, exp);
      else pass_cnt++;
    end
    repeat (3) tick();
    $display("test_abort: mid-sequence reset checked");
  endtask

  // Second request whose sync edge is k+8, so it acts while count = 7.
  task automatic test_retrig();
    logic [3:0] got, exp;
    repeat (3) tick();
    req_N = 1'b0;
    for (int j = 0; j <= 24; j++) begin
      tick();
      got = {rst_out_N, busy, done};
`ifdef RST_SEQ_RETRIG_EN
      exp = {!(j >= 2 && j < 20), !((j >= 2 && j < 8) || (j >= 10 && j < 16)),
             (j >= 2 && j < 20), (j == 20)};
`else
      exp = {!(j >= 2 && j < 12), !(j >= 2 && j < 8), (j >= 2 && j < 12), (j == 12)};
`endif
      check_cnt++;
      if (got !== exp) $display("FAIL retrig j=%0d out/busy/done=%b expected %b", j, got, exp);
      else pass_cnt++;
      if (j == 2) req_N = 1'b1;
      if (j == 7) req_N = 1'b0;
      if (j == 9) req_N = 1'b1;
    end
    repeat (3) tick();
    $display("test_retrig: request while busy checked");
  endtask

  // Request timed so that trig coincides with the final-release edge (k+12).
  task automatic test_simul();
    logic [3:0] got, exp;
    repeat (3) tick();
    req_N = 1'b0;
    for (int j = 0; j <= 24; j++) begin
      tick();
      got = {rst_out_N, busy, done};
`ifdef RST_SEQ_RETRIG_EN
      exp = {!(j >= 2 && j < 22), !((j >= 2 && j < 8) || (j >= 12 && j < 18)),
             (j >= 2 && j < 22), (j == 22)};
`else
      exp = {!(j >= 2 && j < 12), !(j >= 2 && j < 8), (j >= 2 && j < 12), (j == 12)};
`endif
      check_cnt++;
      if (got !== exp) $display("FAIL simul j=%0d out/busy/done=%b expected %b", j, got, exp);
      else pass_cnt++;
      if (j == 2)  req_N = 1'b1;
      if (j == 9)  req_N = 1'b0;
      if (j == 11) req_N = 1'b1;
    end
    repeat (3) tick();
    $display("test_simul: request on final-release edge checked");
  endtask

  initial begin
    rst_N  = 1'b1;
    rst2_N = 1'b1;
    req_N  = 1'b1;
    req2_N = 1'b1;
    #2;
    rst_N  = 1'b0;
    rst2_N = 1'b0;
    test_reset();
    test_soft();
    test_short();
    test_abort();
    test_retrig();
    test_simul();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Parametrised reset sequencer for the ESN datapath. It turns a global asynchronous reset, or a soft falling-edge reset request, into a fixed-length reset pulse on N_CH downstream reset lines. The lines are released in staggered order, so the reservoir leaves reset before the readout and the readout sees valid state on its first cycle. It generalises the previous fixed 6-cycle pulse and shift-register delay to any pulse length, stagger and channel count, and adds busy/done status.

## Interface
- N_CH, 2: number of downstream active-low reset channels (>=1)
- PULSE_LEN, 6: cycles all channels are held low before channel 0 releases (>=1)
- DLY, 4: cycles between release of channel i and channel i+1 (>=0; 0 releases all channels together)
- CW, 8: sequence counter width; PULSE_LEN-1+(N_CH-1)*DLY < 2^CW, checked at elaboration
- clk  in  1  system clock, all logic on rising edge
- rst_N  in  1  global reset, asynchronous, active-low
- req_N  in  1  soft reset request, asynchronous to clk; its falling edge triggers a sequence
- rst_out_N  out  N_CH  downstream resets, active-low, registered; bit 0 releases first
- busy  out  1  high while any channel is held in reset by a sequence
- done  out  1  one-cycle pulse when the last channel releases

## Operation
- req_N passes through a 2-flop synchroniser (sync[0], then sync[1]); both flops reset to 1. trig = sync[1] & ~sync[0].
- FSM states:
  - IDLE: all rst_out_N = 1, busy = 0, count = 0.
  - ASSERT: sequence running; count increments by 1 per edge.
  - No separate done state; done is a registered strobe.
- Async reset (rst_N = 0), effective immediately:
  - state = ASSERT, count = 0, rst_out_N = all 0, busy = 1, done = 0, sync = 11.
- On trig in IDLE, at the next edge: state = ASSERT, count = 0, rst_out_N = all 0, busy = 1.
- In ASSERT, on the edge where count == PULSE_LEN-1+i*DLY, rst_out_N[i] <= 1. Already-released channels stay 1.
- On the edge that releases channel N_CH-1:
  - state <= IDLE, busy <= 0, done <= 1 for one cycle, count <= 0.
- When DLY = 0, all channels and done occur on the same edge.
- rst_out_N bits only rise in ascending index order. No glitches: every output is a flop.

## Timing
- Let E0 be the edge that enters ASSERT (or rst_N deassertion, for power-on). Channel i rises at edge E0+PULSE_LEN+i*DLY.
- busy falls and done pulses at edge E0+PULSE_LEN+(N_CH-1)*DLY.
- Soft-request latency: req_N low sampled at edge k gives trig during cycle k+1, and rst_out_N falls at edge k+2.
- req_N low shorter than one clock period may be missed. Holding req_N low never retriggers; only a new falling edge does.
- rst_N asserted mid-sequence aborts it with no done pulse. After rst_N deassertion a full sequence runs from count 0.

## Configuration
- RST_SEQ_RETRIG_EN defined:
  - trig while busy restarts the sequence at the next edge: rst_out_N = all 0, count = 0, busy stays 1.
  - The aborted sequence emits no done.
  - trig on the same cycle as the final release wins: no done pulse, and the sequence restarts.
- RST_SEQ_RETRIG_EN undefined:
  - trig while busy, including the final-release cycle, is discarded, not queued.
  - The running sequence completes unchanged.

## Test plan
- Power-on, defaults: rst_N low 3 cycles, then high. Required:
  - rst_out_N = 00 and busy = 1 during reset.
  - rst_out_N[0] rises on the 6th edge after deassertion; rst_out_N[1] on the 10th.
  - done is high for exactly that 10th-edge cycle; busy = 0 afterwards.
- Soft request, defaults, in IDLE: req_N falls, sampled at edge k. Required:
  - rst_out_N = 00 from edge k+2.
  - bit 0 rises at k+8, bit 1 at k+12, done at k+12.
  - Holding req_N low afterwards causes no second sequence.
- Parameters N_CH=4, PULSE_LEN=1, DLY=0: trigger. Required:
  - rst_out_N = 0000 for exactly one cycle, then 1111.
  - busy high for one cycle; done on the release edge.
- rst_N pulsed low 1 cycle at count = 3 of a soft sequence. Required:
  - Outputs drop to 00 immediately, with no done.
  - Full 6/10-cycle sequence restarts from deassertion.
- Retrigger at count = 7, defaults:
  - With RST_SEQ_RETRIG_EN: rst_out_N[0] falls back to 0; one done, 12 edges after the retrigger's sync edge.
  - Without it: sequence finishes at original E0+10 with a single done.
- Simultaneous trig and final release:
  - Macro on: no done, new sequence.
  - Macro off: done pulses, then IDLE with rst_out_N = 11.
